// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame states and CPOL/CPHA decode.
// Used by both spi_slave and spi_master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  function automatic logic mode_cpol(
    input logic [1:0] m
  );
    return m[CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(
    input logic [1:0] m
  );
    return m[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third copy for edge detection.
// Resets to the line's idle level so no false edge follows reset.
module spi_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= IDLE_LVL;
      r_sync <= IDLE_LVL;
      r_prev <= IDLE_LVL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled sclk/ss_n, configurable mode and width,
// rx word buffer with valid/ack, tx holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int MODE       = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  irq,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic CPOL = mode_cpol(2'(MODE));
  localparam logic CPHA = mode_cpha(2'(MODE));
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic w_unused_sclk;
  logic w_sclk_rise, w_sclk_fall;
  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_lead, w_trail, w_samp, w_shft;
  logic w_mosi;
  logic w_start, w_done, w_abort;

  spi_state_e r_state, w_next;

  logic          r_mosi_meta, r_mosi_sync;
  logic [1:0]    r_age;
  logic          r_armed;
  logic [DW-1:0] r_hold, r_shift, r_rx_data;
  logic [DW-2:0] r_rx;
  logic [CW-1:0] r_cnt;
  logic          r_rx_valid, r_irq, r_ovr, r_ferr;

  spi_sync_edge #(.IDLE_LVL(CPOL)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sclk),
    .o_sync (w_unused_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.IDLE_LVL(1'b1)) u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ss_n),
    .o_sync (w_ss_sync),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_mosi  = r_mosi_sync;
  assign w_lead  = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_samp  = CPHA ? w_trail : w_lead;
  assign w_shft  = CPHA ? w_lead : w_trail;

  // Arm only once a real (post-reset) ss_n high has been synchronized.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_age   <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (!r_age[1]) r_age <= r_age + 2'd1;
      if (r_age[1] && w_ss_sync) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall && r_armed) begin
          w_next  = SHIFT;
          w_start = 1'b1;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (w_samp && r_cnt == LAST) begin
          w_next = WAIT_DESEL;
          w_done = 1'b1;
        end
      end
      WAIT_DESEL: begin
        if (w_ss_rise) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_shift    <= '0;
      r_rx       <= '0;
      r_cnt      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_irq      <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_irq  <= w_done;
      r_ovr  <= w_done && r_rx_valid && !rx_ack;
      r_ferr <= w_abort;
      if (tx_load) r_hold <= tx_data;
      if (w_start) begin
        r_shift <= r_hold;
        r_cnt   <= '0;
      end else if (r_state == SHIFT && !w_ss_rise) begin
        if (w_samp) begin
          r_rx  <= {r_rx[DW-3:0], w_mosi};
          r_cnt <= r_cnt + CW'(1);
        end
        // CPHA=1: first leading edge presents the preloaded MSB.
        if (w_shft && (!CPHA || r_cnt != '0))
          r_shift <= {r_shift[DW-2:0], 1'b0};
      end
      if (w_done) begin
        r_rx_data  <= {r_rx, w_mosi};
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign miso_oe   = !w_ss_sync && (r_state != IDLE);
  assign miso      = miso_oe & r_shift[DW-1];
  assign busy      = (r_state != IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign irq       = r_irq;
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter MODE, default 3, SPI mode 0-3 (MODE[1]=CPOL, MODE[0]=CPHA).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, frame length in bits, legal range 8-32.
REQ-003 SHALL have port clk  input  1  system clock, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port ss_n  input  1  slave select, active-low, asynchronous.
REQ-007 SHALL have port mosi  input  1  serial data from master, asynchronous.
REQ-008 SHALL have port miso  output  1  serial data to master.
REQ-009 SHALL have port miso_oe  output  1  miso drive enable, high while selected.
REQ-010 SHALL have port tx_data  input  DATA_WIDTH  next response word.
REQ-011 SHALL have port tx_load  input  1  one-cycle strobe capturing tx_data.
REQ-012 SHALL have port rx_data  output  DATA_WIDTH  last complete received word.
REQ-013 SHALL have port rx_valid  output  1  level, new rx_data present.
REQ-014 SHALL have port rx_ack  input  1  one-cycle strobe clearing rx_valid.
REQ-015 SHALL have port busy  output  1  high while a frame is in progress.
REQ-016 SHALL have port irq  output  1  one-cycle pulse on frame completion.
REQ-017 SHALL have port overrun  output  1  one-cycle pulse when completion finds rx_valid still high.
REQ-018 SHALL have port frame_err  output  1  one-cycle pulse when ss_n rises mid-frame.

Function
REQ-019 SHALL pass sclk, ss_n and mosi through 2-flop synchronizers, then detect sclk and ss_n edges from the synchronized value and a third registered copy.
REQ-020 SHALL support sclk half-periods of at least 4 clk cycles; slower sclk is unconstrained.
REQ-021 SHALL define leading edge as rising for CPOL=0 and falling for CPOL=1.
REQ-022 SHALL sample mosi on leading edges for CPHA=0 and on trailing edges for CPHA=1, MSB first.
REQ-023 SHALL shift miso on trailing edges for CPHA=0 and on leading edges for CPHA=1.
REQ-024 SHALL implement states IDLE, SHIFT and WAIT_DESEL.
REQ-025 SHALL go IDLE->SHIFT on a synchronized ss_n falling edge, loading the tx holding register into the shift register and clearing the bit counter.
REQ-026 SHALL drive the shift-register MSB on miso from the cycle after SHIFT entry, so CPHA=0 first bit is valid before the first sclk edge.
REQ-027 SHALL go SHIFT->WAIT_DESEL on the DATA_WIDTH-th sample edge, and in the same cycle load rx_data, set rx_valid and pulse irq.
REQ-028 SHALL pulse overrun, with rx_data overwritten, when REQ-027 completion occurs while rx_valid is high and rx_ack is low.
REQ-029 SHALL let completion win over a same-cycle rx_ack, leaving rx_valid high.
REQ-030 SHALL ignore sclk edges in WAIT_DESEL, and go WAIT_DESEL->IDLE on ss_n rising.
REQ-031 SHALL on ss_n rising in SHIFT go to IDLE, pulse frame_err, discard partial bits and leave rx_data/rx_valid unchanged.
REQ-032 SHALL hold busy high in SHIFT and WAIT_DESEL, and miso_oe high whenever synchronized ss_n is low and state is not IDLE.
REQ-033 SHALL capture tx_data into the holding register on tx_load in any state; a load during a frame applies to the next frame; an unreloaded holding value is resent.
REQ-034 SHALL drive miso low when miso_oe is low.

Reset
REQ-035 SHALL reset to: state IDLE, miso 0, miso_oe 0, rx_data 0, rx_valid 0, busy 0, irq 0, overrun 0, frame_err 0, holding and shift registers 0, synchronizers to idle levels (sclk=CPOL, ss_n=1).
REQ-036 SHALL on reset mid-frame discard the frame; if ss_n is still low after reset, SHALL not start a frame until ss_n has been seen high.

Structure
REQ-037 SHALL put the state enum and CPOL/CPHA decode constants in shared package spi_pkg, also usable by spi_master.
REQ-038 SHALL implement REQ-019 in one sub-module, spi_sync_edge (2-flop sync plus rise/fall detect), instantiated for sclk and ss_n; mosi uses sync only.

Verification
REQ-039 SHALL check: MODE 3, master sends 0x0000AA55 while tx_data=0x12345678 -> rx_data=0x0000AA55, one irq pulse, miso stream 0x12345678 MSB first.
REQ-040 SHALL check: MODE 0, first bit valid before first rising sclk; mosi 0xCCCCCCCC -> rx_data=0xCCCCCCCC.
REQ-041 SHALL check: two frames without rx_ack -> second completion gives one overrun pulse and rx_data=second word.
REQ-042 SHALL check: ss_n raised after 10 bits -> one frame_err pulse, no irq, rx_valid and rx_data unchanged, busy low.
REQ-043 SHALL check: rst_n low for 2 cycles mid-frame with ss_n held low -> all outputs at reset values, no frame until ss_n toggles high then low.
REQ-044 SHALL check: tx_load 0x1111 during a frame -> current frame sends old word, next frame sends 0x00001111.
